// File: rtl/contador_bcd_ud.sv
// contador_bcd_ud: multi-digit up/down modulo counter with carry/borrow chain, clamped load, wrap or saturate ends.
// Optional q_cap snapshot register enabled by defining CONTADOR_BCD_CAPTURE_EN.
module contador_bcd_ud #(
    parameter int DIGITS = 3,
    parameter int MOD    = 10,
    parameter int W      = 4,
    parameter int WRAP   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                soft_reset,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_val,
    input  logic                tick,
    input  logic                up_down,
`ifdef CONTADOR_BCD_CAPTURE_EN
    input  logic                capture,
    output logic [DIGITS*W-1:0] q_cap,
`endif
    output logic [DIGITS*W-1:0] q,
    output logic                max_tick,
    output logic                min_tick,
    output logic                ovf
);
    localparam logic [W-1:0] TOP  = W'(MOD - 1);
    localparam logic [W:0]   MODV = (W + 1)'(MOD);

    logic [DIGITS*W-1:0] q_q, q_d, stepped, clamped;
    logic [DIGITS-1:0]   at_max, at_min, cin;
    logic                ovf_q, ovf_d, end_hit;

    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_digit
        logic [W-1:0] d, ld;
        assign d  = q_q[g*W +: W];
        assign ld = load_val[g*W +: W];
        assign at_max[g] = d == TOP;
        assign at_min[g] = d == '0;
        // carry/borrow reaches digit g only when every lower digit sits at the relevant end
        if (g == 0) begin : g_lsd
            assign cin[g] = 1'b1;
        end else begin : g_hi
            assign cin[g] = up_down ? &at_max[g-1:0] : &at_min[g-1:0];
        end
        assign stepped[g*W +: W] = !cin[g] ? d :
                                   up_down ? (at_max[g] ? '0 : d + 1'b1) :
                                             (at_min[g] ? TOP : d - 1'b1);
        assign clamped[g*W +: W] = ({1'b0, ld} >= MODV) ? TOP : ld;
    end

    assign max_tick = &at_max;
    assign min_tick = &at_min;
    assign end_hit  = up_down ? max_tick : min_tick;

    // at a range end the chain already produces the wrapped value; saturation just holds
    always_comb begin
        q_d   = soft_reset ? '0 :
                load       ? clamped :
                (tick && !(end_hit && WRAP == 0)) ? stepped : q_q;
        ovf_d = !soft_reset && !load && tick && end_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

`ifdef CONTADOR_BCD_CAPTURE_EN
    logic [DIGITS*W-1:0] cap_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cap_q <= '0;
        else if (capture) cap_q <= q_q;
    end
    assign q_cap = cap_q;
`endif
endmodule

// File: tb/tb_contador_bcd_ud.sv
// tb_contador_bcd_ud: directed checks of a wrapping and a saturating instance driven by shared inputs.
module tb_contador_bcd_ud;
    logic        clk = 1'b0, reset = 1'b1, soft_reset = 1'b0, load = 1'b0, tick = 1'b0, up_down = 1'b1;
    logic [11:0] load_val = '0;
    logic [11:0] q_w, q_s;
    logic        mx_w, mn_w, ov_w, mx_s, mn_s, ov_s;
    int          checks = 0, failures = 0;
`ifdef CONTADOR_BCD_CAPTURE_EN
    logic        capture = 1'b0;
    logic [11:0] qc_w, qc_s;
`endif

    always #5 clk = ~clk;

    contador_bcd_ud #(.DIGITS(3), .MOD(10), .W(4), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .soft_reset(soft_reset), .load(load), .load_val(load_val),
        .tick(tick), .up_down(up_down),
`ifdef CONTADOR_BCD_CAPTURE_EN
        .capture(capture), .q_cap(qc_w),
`endif
        .q(q_w), .max_tick(mx_w), .min_tick(mn_w), .ovf(ov_w));

    contador_bcd_ud #(.DIGITS(3), .MOD(10), .W(4), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .soft_reset(soft_reset), .load(load), .load_val(load_val),
        .tick(tick), .up_down(up_down),
`ifdef CONTADOR_BCD_CAPTURE_EN
        .capture(capture), .q_cap(qc_s),
`endif
        .q(q_s), .max_tick(mx_s), .min_tick(mn_s), .ovf(ov_s));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; soft_reset = 1'b0; load = 1'b0; tick = 1'b0; up_down = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (q_w !== 12'h000) begin failures++; $display("FAIL reset_q_wrap got=%h exp=000", q_w); end
        checks++; if (q_s !== 12'h000) begin failures++; $display("FAIL reset_q_sat got=%h exp=000", q_s); end
        checks++; if ({ov_w, ov_s} !== 2'b00) begin failures++; $display("FAIL reset_ovf got=%b exp=00", {ov_w, ov_s}); end
        checks++; if ({mn_w, mx_w} !== 2'b10) begin failures++; $display("FAIL reset_min_max got=%b exp=10", {mn_w, mx_w}); end
    endtask

    task automatic test_up_carry();
        logic [11:0] e;
        do_reset();
        up_down = 1'b1; tick = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            int n;
            cyc();
            n = k % 1000;
            e = 12'(((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10));
            checks++; if (q_w !== e) begin failures++; $display("FAIL up_q tick=%0d got=%h exp=%h", k, q_w, e); end
            checks++; if (ov_w !== (k == 1000)) begin failures++; $display("FAIL up_ovf tick=%0d got=%b exp=%b", k, ov_w, k == 1000); end
            checks++; if (mx_w !== (k == 999)) begin failures++; $display("FAIL up_max tick=%0d got=%b exp=%b", k, mx_w, k == 999); end
        end
        checks++; if (q_s !== 12'h999 || ov_s !== 1'b1) begin failures++; $display("FAIL up_sat_end got=%h/%b exp=999/1", q_s, ov_s); end
        tick = 1'b0;
        cyc();
        checks++; if ({ov_w, ov_s} !== 2'b00) begin failures++; $display("FAIL up_ovf_drop got=%b exp=00", {ov_w, ov_s}); end
        checks++; if (q_w !== 12'h000) begin failures++; $display("FAIL up_hold got=%h exp=000", q_w); end
    endtask

    task automatic test_down_zero();
        do_reset();
        up_down = 1'b0; tick = 1'b1;
        cyc();
        tick = 1'b0;
        checks++; if (q_w !== 12'h999 || ov_w !== 1'b1) begin failures++; $display("FAIL down_wrap got=%h/%b exp=999/1", q_w, ov_w); end
        checks++; if (q_s !== 12'h000 || ov_s !== 1'b1) begin failures++; $display("FAIL down_sat got=%h/%b exp=000/1", q_s, ov_s); end
        checks++; if (mn_s !== 1'b1 || mx_w !== 1'b1) begin failures++; $display("FAIL down_flags got=%b%b exp=11", mn_s, mx_w); end
        cyc();
        checks++; if ({ov_w, ov_s} !== 2'b00) begin failures++; $display("FAIL down_ovf_drop got=%b exp=00", {ov_w, ov_s}); end
    endtask

    task automatic test_load_clamp();
        logic [11:0] exp_seq [3] = '{12'h948, 12'h949, 12'h950};
        do_reset();
        load = 1'b1; load_val = 12'hC47;
        cyc();
        load = 1'b0; tick = 1'b1; up_down = 1'b1;
        checks++; if (q_w !== 12'h947 || q_s !== 12'h947) begin failures++; $display("FAIL load_clamp got=%h/%h exp=947", q_w, q_s); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (q_w !== exp_seq[i]) begin failures++; $display("FAIL load_step%0d got=%h exp=%h", i, q_w, exp_seq[i]); end
        end
        tick = 1'b0;
    endtask

    task automatic test_priority();
        soft_reset = 1'b1; load = 1'b1; load_val = 12'h555; tick = 1'b1; up_down = 1'b1;
        cyc();
        soft_reset = 1'b0;
        checks++; if (q_w !== 12'h000 || ov_w !== 1'b0) begin failures++; $display("FAIL prio_soft got=%h/%b exp=000/0", q_w, ov_w); end
        cyc();
        load = 1'b0; tick = 1'b0;
        checks++; if (q_w !== 12'h555 || q_s !== 12'h555) begin failures++; $display("FAIL prio_load got=%h/%h exp=555", q_w, q_s); end
    endtask

    task automatic test_saturate();
        logic [11:0] ew [4] = '{12'h999, 12'h000, 12'h001, 12'h002};
        logic [3:0]  eo_s = 4'b1110, eo_w = 4'b0010;
        load = 1'b1; load_val = 12'h998;
        cyc();
        load = 1'b0; tick = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (q_s !== 12'h999 || ov_s !== eo_s[i]) begin failures++; $display("FAIL sat_hold%0d got=%h/%b exp=999/%b", i, q_s, ov_s, eo_s[i]); end
            checks++; if (q_w !== ew[i] || ov_w !== eo_w[i]) begin failures++; $display("FAIL sat_wrap%0d got=%h/%b exp=%h/%b", i, q_w, ov_w, ew[i], eo_w[i]); end
        end
        tick = 1'b0;
    endtask

    task automatic test_direction();
        logic [11:0] e [4] = '{12'h099, 12'h100, 12'h099, 12'h098};
        logic [3:0]  dir = 4'b0010;
        load = 1'b1; load_val = 12'h100;
        cyc();
        load = 1'b0; tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_down = dir[i];
            cyc();
            checks++; if (q_w !== e[i]) begin failures++; $display("FAIL dir_step%0d got=%h exp=%h", i, q_w, e[i]); end
        end
        tick = 1'b0; up_down = 1'b1;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 12'h123;
        cyc();
        load = 1'b0;
        checks++; if (q_w !== 12'h123) begin failures++; $display("FAIL async_pre got=%h exp=123", q_w); end
`ifdef CONTADOR_BCD_CAPTURE_EN
        capture = 1'b1; tick = 1'b1;
        cyc();
        capture = 1'b0; tick = 1'b0;
        checks++; if (qc_w !== 12'h123 || q_w !== 12'h124) begin failures++; $display("FAIL capture got=%h/%h exp=123/124", qc_w, q_w); end
        soft_reset = 1'b1;
        cyc();
        soft_reset = 1'b0;
        checks++; if (qc_w !== 12'h123 || q_w !== 12'h000) begin failures++; $display("FAIL capture_soft got=%h/%h exp=123/000", qc_w, q_w); end
        load = 1'b1;
        cyc();
        load = 1'b0;
`endif
        #2 reset = 1'b1;
        #1;
        checks++; if (q_w !== 12'h000 || q_s !== 12'h000) begin failures++; $display("FAIL async_clear got=%h/%h exp=000", q_w, q_s); end
        #1 reset = 1'b0;
        tick = 1'b1; up_down = 1'b1;
        cyc();
        tick = 1'b0;
        checks++; if (q_w !== 12'h001) begin failures++; $display("FAIL async_resume got=%h exp=001", q_w); end
    endtask

    initial begin
        test_reset();
        test_up_carry();
        test_down_zero();
        test_load_clamp();
        test_priority();
        test_saturate();
        test_direction();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
